// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO
module ex_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Flush,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             ReadHiLo,
    input  logic             WriteHi,
    input  logic             WriteLo,
    input  logic [WIDTH-1:0] MoveData,
    output logic             Stall,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero,
    output logic [WIDTH-1:0] HI_Out,
    output logic [WIDTH-1:0] LO_Out
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Iteration state: {acc_q, low_q} is the shared 2*WIDTH working register.
    // Multiply: acc = partial product high half, low = multiplier / product low half.
    // Divide:   acc = partial remainder,          low = dividend / quotient.
    logic [CW-1:0]    cnt_q;
    logic             iter_done_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] low_q;
    logic [WIDTH-1:0] b_q;
    logic             is_div_q;
    logic             b_zero_q;
    logic             neg_main_q;   // negate product or quotient at the end
    logic             neg_rem_q;    // negate remainder at the end

    logic             start_op;
    logic             finish_op;
    logic             op_signed;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_sub;
    logic [2*WIDTH-1:0] prod_mag;
    logic [2*WIDTH-1:0] prod_res;
    logic [WIDTH-1:0]   quo_res;
    logic [WIDTH-1:0]   rem_res;

    assign start_op  = (state_q == ST_IDLE) && Start && !Flush;
    assign finish_op = (state_q == ST_BUSY) && iter_done_q && !Flush;

    // Signed ops run on magnitudes; signs are reapplied when the result is written.
    assign op_signed = ~Op[0];
    assign a_mag     = (op_signed && A[WIDTH-1]) ? -A : A;
    assign b_mag     = (op_signed && B[WIDTH-1]) ? -B : B;

    // One radix-2 shift-add step and one restoring-divide step.
    assign mul_sum   = {1'b0, acc_q} + (low_q[0] ? {1'b0, b_q} : '0);
    assign div_shift = {acc_q, low_q[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, b_q};
    assign div_sub   = div_shift[WIDTH-1:0] - b_q;

    assign prod_mag  = {acc_q, low_q};
    assign prod_res  = neg_main_q ? -prod_mag : prod_mag;
    assign quo_res   = neg_main_q ? -low_q : low_q;
    assign rem_res   = neg_rem_q ? -acc_q : acc_q;

    // State register.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and pipeline stall; DONE always falls back to IDLE so a held Start cannot restart.
    always_comb begin
        state_d = state_q;
        Stall   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                Stall = Start && !Flush;
                if (Start && !Flush) begin
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                Stall = 1'b1 | ReadHiLo;
                if (Flush) begin
                    state_d = ST_IDLE;
                end else if (iter_done_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Operand capture and one iteration per BUSY cycle until all WIDTH steps are done.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            cnt_q       <= '0;
            iter_done_q <= 1'b0;
            acc_q       <= '0;
            low_q       <= '0;
            b_q         <= '0;
            is_div_q    <= 1'b0;
            b_zero_q    <= 1'b0;
            neg_main_q  <= 1'b0;
            neg_rem_q   <= 1'b0;
        end else if (start_op) begin
            cnt_q       <= '0;
            iter_done_q <= 1'b0;
            acc_q       <= '0;
            low_q       <= a_mag;
            b_q         <= b_mag;
            is_div_q    <= Op[1];
            b_zero_q    <= (B == '0);
            neg_main_q  <= op_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
            neg_rem_q   <= op_signed && A[WIDTH-1];
        end else if ((state_q == ST_BUSY) && !iter_done_q) begin
            if (is_div_q) begin
                acc_q <= div_ge ? div_sub : div_shift[WIDTH-1:0];
                low_q <= {low_q[WIDTH-2:0], div_ge};
            end else begin
                acc_q <= mul_sum[WIDTH:1];
                low_q <= {mul_sum[0], low_q[WIDTH-1:1]};
            end
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST_ITER) begin
                iter_done_q <= 1'b1;
            end
        end
    end

    // HI/LO: result write on entry to DONE (skipped for divide by zero), MTHI/MTLO only when idle.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            HI_Out <= '0;
            LO_Out <= '0;
        end else if (finish_op) begin
            if (!is_div_q) begin
                HI_Out <= prod_res[2*WIDTH-1:WIDTH];
                LO_Out <= prod_res[WIDTH-1:0];
            end else if (!b_zero_q) begin
                HI_Out <= rem_res;
                LO_Out <= quo_res;
            end
        end else if ((state_q == ST_IDLE) && !Start) begin
            if (WriteHi) begin
                HI_Out <= MoveData;
            end
            if (WriteLo) begin
                LO_Out <= MoveData;
            end
        end
    end

    // Registered status flags mirror the state being entered.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            Busy      <= 1'b0;
            Done      <= 1'b0;
            DivByZero <= 1'b0;
        end else begin
            Busy      <= (state_d == ST_BUSY);
            Done      <= (state_d == ST_DONE);
            DivByZero <= (state_d == ST_DONE) && is_div_q && b_zero_q;
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb/tb_ex_muldiv_unit.sv - directed self-checking bench for ex_muldiv_unit
module tb_ex_muldiv_unit;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Flush;
    logic        Start;
    logic [1:0]  Op;
    logic [31:0] A;
    logic [31:0] B;
    logic        ReadHiLo;
    logic        WriteHi;
    logic        WriteLo;
    logic [31:0] MoveData;
    logic        Stall;
    logic        Busy;
    logic        Done;
    logic        DivByZero;
    logic [31:0] HI_Out;
    logic [31:0] LO_Out;

    int checks = 0;
    int errors = 0;

    int          stall_cnt;
    int          done_at;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_dbz;
    logic        pre_stall;
    logic        post_busy;
    logic        post_done;
    logic        post_dbz;
    logic        seen_done;

    ex_muldiv_unit #(.WIDTH(32)) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Flush     (Flush),
        .Start     (Start),
        .Op        (Op),
        .A         (A),
        .B         (B),
        .ReadHiLo  (ReadHiLo),
        .WriteHi   (WriteHi),
        .WriteLo   (WriteLo),
        .MoveData  (MoveData),
        .Stall     (Stall),
        .Busy      (Busy),
        .Done      (Done),
        .DivByZero (DivByZero),
        .HI_Out    (HI_Out),
        .LO_Out    (LO_Out)
    );

    always #5 Clock = ~Clock;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one operation with Start held until the instruction leaves ID/EX at t0+34.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic rhl);
        @(negedge Clock);
        Op = op; A = a; B = b; ReadHiLo = rhl; Start = 1'b1;
        #1 pre_stall = Stall;
        stall_cnt = 0;
        done_at   = -1;
        r_hi = '0; r_lo = '0; r_dbz = 1'b0;
        @(posedge Clock);
        for (int k = 0; k <= 33; k++) begin
            @(negedge Clock);
            if (Stall) stall_cnt++;
            if (Done && done_at < 0) done_at = k;
            if (k == 33) begin
                r_hi  = HI_Out;
                r_lo  = LO_Out;
                r_dbz = DivByZero;
            end
        end
        @(posedge Clock);
        #1 Start = 1'b0; ReadHiLo = 1'b0;
        @(negedge Clock);
        post_busy = Busy;
        post_done = Done;
        post_dbz  = DivByZero;
    endtask

    task automatic move(input logic hi_en, input logic lo_en, input logic [31:0] data);
        @(negedge Clock);
        WriteHi = hi_en; WriteLo = lo_en; MoveData = data;
        @(posedge Clock);
        #1 WriteHi = 1'b0; WriteLo = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        Reset = 1'b0; Flush = 1'b0; Start = 1'b0; Op = 2'b00; A = '0; B = '0;
        ReadHiLo = 1'b0; WriteHi = 1'b0; WriteLo = 1'b0; MoveData = '0;
        repeat (2) @(posedge Clock);
        #1 Reset = 1'b1;
        @(negedge Clock);
        check_val("rst_busy",  64'(Busy),      64'h0);
        check_val("rst_done",  64'(Done),      64'h0);
        check_val("rst_dbz",   64'(DivByZero), 64'h0);
        check_val("rst_hi",    64'(HI_Out),    64'h0);
        check_val("rst_lo",    64'(LO_Out),    64'h0);
        check_val("rst_stall", 64'(Stall),     64'h0);

        // MULT -2 * 3
        run_op(2'b00, 32'hFFFF_FFFE, 32'd3, 1'b0);
        check_val("mult_prestall", 64'(pre_stall), 64'h1);
        check_val("mult_stallcnt", 64'(stall_cnt), 64'd33);
        check_val("mult_done_at",  64'(done_at),   64'd33);
        check_val("mult_hi",       64'(r_hi),      64'hFFFF_FFFF);
        check_val("mult_lo",       64'(r_lo),      64'hFFFF_FFFA);
        check_val("mult_dbz",      64'(r_dbz),     64'h0);
        check_val("mult_postbusy", 64'(post_busy), 64'h0);
        check_val("mult_postdone", 64'(post_done), 64'h0);

        // MULTU max * max, with ReadHiLo asserted during BUSY, then MFHI
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        check_val("multu_stallcnt", 64'(stall_cnt), 64'd33);
        check_val("multu_done_at",  64'(done_at),   64'd33);
        check_val("multu_hi",       64'(r_hi),      64'hFFFF_FFFE);
        check_val("multu_lo",       64'(r_lo),      64'h0000_0001);
        check_val("multu_norestart", 64'(post_busy), 64'h0);
        @(negedge Clock);
        ReadHiLo = 1'b1;
        #1;
        check_val("mfhi_stall", 64'(Stall),  64'h0);
        check_val("mfhi_hi",    64'(HI_Out), 64'hFFFF_FFFE);
        ReadHiLo = 1'b0;

        // DIV -7 / 2
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
        check_val("div_lo",  64'(r_lo),  64'hFFFF_FFFD);
        check_val("div_hi",  64'(r_hi),  64'hFFFF_FFFF);
        check_val("div_dbz", 64'(r_dbz), 64'h0);

        // DIV overflow case
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check_val("divovf_lo", 64'(r_lo), 64'h8000_0000);
        check_val("divovf_hi", 64'(r_hi), 64'h0);

        // DIVU 100 / 7
        run_op(2'b11, 32'd100, 32'd7, 1'b0);
        check_val("divu_lo", 64'(r_lo), 64'd14);
        check_val("divu_hi", 64'(r_hi), 64'd2);

        // MTHI/MTLO then DIVU by zero
        move(1'b1, 1'b0, 32'd5);
        move(1'b0, 1'b1, 32'd9);
        @(negedge Clock);
        check_val("mthi", 64'(HI_Out), 64'd5);
        check_val("mtlo", 64'(LO_Out), 64'd9);
        run_op(2'b11, 32'd100, 32'd0, 1'b0);
        check_val("dz_done_at",  64'(done_at),  64'd33);
        check_val("dz_dbz",      64'(r_dbz),    64'h1);
        check_val("dz_hi",       64'(r_hi),     64'd5);
        check_val("dz_lo",       64'(r_lo),     64'd9);
        check_val("dz_postdbz",  64'(post_dbz), 64'h0);

        // Flush overrides Start in IDLE
        @(negedge Clock);
        Op = 2'b00; A = 32'd3; B = 32'd4; Start = 1'b1; Flush = 1'b1;
        #1 check_val("idleflush_stall", 64'(Stall), 64'h0);
        @(posedge Clock);
        #1 Start = 1'b0; Flush = 1'b0;
        @(negedge Clock);
        check_val("idleflush_busy", 64'(Busy), 64'h0);

        // Flush at iteration 10 of DIV, with an MTHI attempt during BUSY
        @(negedge Clock);
        Op = 2'b10; A = 32'd50; B = 32'd3; Start = 1'b1;
        @(posedge Clock);
        repeat (5) @(posedge Clock);
        #1 WriteHi = 1'b1; MoveData = 32'h0000_DEAD;
        @(posedge Clock);
        #1 WriteHi = 1'b0;
        repeat (4) @(posedge Clock);
        #1 Flush = 1'b1;
        @(posedge Clock);
        #1 Flush = 1'b0; Start = 1'b0;
        @(negedge Clock);
        check_val("flush_busy",  64'(Busy),  64'h0);
        check_val("flush_stall", 64'(Stall), 64'h0);
        seen_done = 1'b0;
        repeat (40) begin
            @(negedge Clock);
            if (Done || DivByZero) seen_done = 1'b1;
        end
        check_val("flush_nodone", 64'(seen_done), 64'h0);
        check_val("flush_hi",     64'(HI_Out),    64'd5);
        check_val("flush_lo",     64'(LO_Out),    64'd9);

        // Reset at iteration 20 of MULT
        @(negedge Clock);
        Op = 2'b00; A = 32'd7; B = 32'd9; Start = 1'b1;
        @(posedge Clock);
        repeat (20) @(posedge Clock);
        #1 Reset = 1'b0;
        @(posedge Clock);
        #1 Reset = 1'b1; Start = 1'b0;
        @(negedge Clock);
        check_val("midrst_hi",    64'(HI_Out),    64'h0);
        check_val("midrst_lo",    64'(LO_Out),    64'h0);
        check_val("midrst_busy",  64'(Busy),      64'h0);
        check_val("midrst_done",  64'(Done),      64'h0);
        check_val("midrst_dbz",   64'(DivByZero), 64'h0);
        check_val("midrst_stall", 64'(Stall),     64'h0);

        // Unit still works after a mid-operation reset
        run_op(2'b00, 32'd7, 32'd9, 1'b0);
        check_val("after_rst_hi", 64'(r_hi), 64'h0);
        check_val("after_rst_lo", 64'(r_lo), 64'd63);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
